// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA core memory arbiter.
//   - CSR_AW / CSR_DW : word-address and data widths of the memory CSR bus.
//   - arb_state_t     : CPU-side arbiter FSM encoding.
//   - cpu_req_t       : one captured CPU Wishbone access (address, direction,
//                       byte lanes, write data).
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int CSR_AW = 17;   // word address, bits [17:1] of the byte address
   localparam int CSR_DW = 16;
   localparam int CSR_SW = CSR_DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,   // waiting for a CPU request
      ST_PEND    = 2'd1,   // request held, waiting for an idle memory cycle
      ST_RD_DATA = 2'd2,   // read issued last cycle, data arriving now
      ST_ACK     = 2'd3    // single-cycle acknowledge to the CPU
   } arb_state_t;

   typedef struct packed {
      logic [CSR_AW-1:0] adr;
      logic              we;
      logic [CSR_SW-1:0] sel;
      logic [CSR_DW-1:0] dat;
   } cpu_req_t;

   localparam cpu_req_t CPU_REQ_NONE = '0;

endpackage

// File: rtl/vga_mem_hold.sv
// -----------------------------------------------------------------------------
// vga_mem_hold
// Holds the captured CPU request while it waits for a free memory cycle and
// counts how long it has been waiting.
//
// Ports:
//   clk      in   video clock
//   rst      in   synchronous active-high reset
//   load     in   capture req_in into the hold register this cycle
//   req_in   in   live CPU request fields
//   pend     in   arbiter is in PEND (counter increments, starvation valid)
//   wait_clr in   clear the wait counter (arbiter idle)
//   req      out  held request
//   starve   out  request has waited MAX_WAIT or more cycles while pending
// -----------------------------------------------------------------------------
module vga_mem_hold
   import vga_pkg::*;
#(
   parameter logic [7:0] MAX_WAIT = 8'd200
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  cpu_req_t req_in,
   input  logic     pend,
   input  logic     wait_clr,
   output cpu_req_t req,
   output logic     starve
);

   logic [7:0] wait_cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the hold register is a handful of flops, not a RAM, so it is
         // reset along with the control state; a stale request can then never
         // leak onto the bus after reset.
         req <= CPU_REQ_NONE;
      end else if (load) begin
         req <= req_in;
      end
   end

   // Saturating wait counter: cleared while idle, counts PEND cycles, and
   // sticks at 255 so a very long starvation never wraps back below MAX_WAIT.
   always_ff @(posedge clk) begin
      if (rst || wait_clr) begin
         wait_cnt <= 8'd0;
      end else if (pend && (wait_cnt != 8'hFF)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign starve = pend && (wait_cnt >= MAX_WAIT);

endmodule

// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
// Shares the video-memory CSR port between the display fetch path and the
// CPU Wishbone slave. The display always wins and passes straight through;
// a CPU access is captured, held, and issued in the first cycle the display
// leaves the bus idle.
//
// Ports:
//   clk, rst              video clock, synchronous active-high reset
//   disp_adr_i/stb_i      display fetch word address / read strobe
//   disp_dat_o            display read data (memory data, 1 cycle later)
//   wb_cyc_i/stb_i/we_i   CPU Wishbone classic request
//   wb_adr_i/sel_i/dat_i  CPU word address, byte lanes, write data
//   wb_dat_o, wb_ack_o    CPU read data and acknowledge (registered)
//   csr_adr_o/stb_o/we_o  memory address, strobe, write enable
//   csr_sel_o/dat_o       memory byte lanes and write data
//   csr_dat_i             memory read data (valid 1 cycle after a read strobe)
//   starve_o              CPU request pending for MAX_WAIT cycles or more
// -----------------------------------------------------------------------------
module vga_mem_arbiter
   import vga_pkg::*;
#(
   parameter logic [7:0] MAX_WAIT = 8'd200
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [CSR_AW:1]   disp_adr_i,
   input  logic              disp_stb_i,
   output logic [CSR_DW-1:0] disp_dat_o,

   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [CSR_AW:1]   wb_adr_i,
   input  logic [CSR_SW-1:0] wb_sel_i,
   input  logic [CSR_DW-1:0] wb_dat_i,
   output logic [CSR_DW-1:0] wb_dat_o,
   output logic              wb_ack_o,

   output logic [CSR_AW:1]   csr_adr_o,
   output logic              csr_stb_o,
   output logic              csr_we_o,
   output logic [CSR_SW-1:0] csr_sel_o,
   output logic [CSR_DW-1:0] csr_dat_o,
   input  logic [CSR_DW-1:0] csr_dat_i,

   output logic              starve_o
);

   arb_state_t state_q, state_d;
   cpu_req_t   req_live, req_held;
   logic       cpu_req_seen;
   logic       in_idle, in_pend;

   assign in_idle = (state_q == ST_IDLE);
   assign in_pend = (state_q == ST_PEND);

   // The ack term keeps a master that still holds stb in the ack cycle from
   // being captured twice.
   assign cpu_req_seen = wb_cyc_i && wb_stb_i && !wb_ack_o;

   assign req_live = '{adr: wb_adr_i, we: wb_we_i, sel: wb_sel_i, dat: wb_dat_i};

   vga_mem_hold #(
      .MAX_WAIT (MAX_WAIT)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (in_idle && cpu_req_seen),
      .req_in   (req_live),
      .pend     (in_pend),
      .wait_clr (in_idle),
      .req      (req_held),
      .starve   (starve_o)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   // Once captured, an access always runs to its ack; dropping wb_cyc_i does
   // not abort it. Only reset does.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (cpu_req_seen) state_d = ST_PEND;
         ST_PEND:    if (!disp_stb_i)  state_d = req_held.we ? ST_ACK : ST_RD_DATA;
         ST_RD_DATA: state_d = ST_ACK;
         ST_ACK:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Display strobe has absolute priority; the held CPU access only drives the
   // bus in a PEND cycle with no display fetch. Otherwise the bus is all-zero.
   always_comb begin
      csr_stb_o = 1'b0;
      csr_we_o  = 1'b0;
      csr_adr_o = '0;
      csr_sel_o = '0;
      csr_dat_o = '0;
      if (disp_stb_i) begin
         csr_stb_o = 1'b1;
         csr_adr_o = disp_adr_i;
         csr_sel_o = '1;
      end else if (in_pend) begin
         csr_stb_o = 1'b1;
         csr_we_o  = req_held.we;
         csr_adr_o = req_held.adr;
         csr_sel_o = req_held.sel;
         csr_dat_o = req_held.dat;
      end
   end

   // Ack is a decode of the state register, so it is glitch-free and lasts
   // exactly the one ACK cycle.
   assign wb_ack_o = (state_q == ST_ACK);

   // Memory read data is a straight pass-through for the display.
   assign disp_dat_o = csr_dat_i;

   // CPU read data is captured in RD_DATA and held until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_dat_o <= '0;
      end else if (state_q == ST_RD_DATA) begin
         wb_dat_o <= csr_dat_i;
      end
   end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Shares the single video-memory CSR port between the display fetch path and the CPU-side Wishbone slave. Display fetches have absolute priority and are never stalled, because pixel timing is fixed. CPU accesses are captured, held, and issued only in memory cycles the display leaves idle. The block sits between the sequencer's CSR read master and the memory CSR slave inside the VGA core.

## Interface
Parameters:
- MAX_WAIT, 8'd200: CPU wait count (in cycles) at which `starve_o` asserts.

Ports:
- clk  in  1  video clock, 25 MHz; single clock domain.
- rst  in  1  synchronous, active-high reset.
- disp_adr_i  in  17 [17:1]  display fetch word address.
- disp_stb_i  in  1  display fetch strobe, read only.
- disp_dat_o  out  16  display read data; valid the cycle after `disp_stb_i`.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  CPU Wishbone classic request.
- wb_adr_i  in  17 [17:1]  CPU word address.
- wb_sel_i  in  2  byte lanes.
- wb_dat_i  in  16  CPU write data.
- wb_dat_o  out  16  CPU read data, registered.
- wb_ack_o  out  1  CPU acknowledge, registered.
- csr_adr_o  out  17 [17:1]  memory address.
- csr_stb_o, csr_we_o  out  1 each  memory strobe and write enable.
- csr_sel_o  out  2  memory byte lanes.
- csr_dat_o  out  16  memory write data.
- csr_dat_i  in  16  memory read data.
- starve_o  out  1  CPU request waiting ≥ MAX_WAIT cycles.

## Operation
- Memory contract:
  - Read data on `csr_dat_i` is valid exactly 1 cycle after a read strobe.
  - A write commits in its strobe cycle.
- Display path is a combinational pass-through:
  - When `disp_stb_i`=1: `csr_adr_o`=`disp_adr_i`, `csr_stb_o`=1, `csr_we_o`=0, `csr_sel_o`=2'b11.
  - `disp_dat_o`=`csr_dat_i` at all times.
- CPU FSM, states IDLE, PEND, RD_DATA, ACK:
  - IDLE: if `wb_cyc_i & wb_stb_i & !wb_ack_o`, latch adr/we/sel/dat into the hold register; go to PEND.
  - PEND: if `disp_stb_i`=0, drive the held access onto the csr bus this cycle. A write goes to ACK; a read goes to RD_DATA. If `disp_stb_i`=1, stay in PEND.
  - RD_DATA: register `csr_dat_i` into `wb_dat_o`; go to ACK. The csr bus is free for the display in this cycle.
  - ACK: `wb_ack_o`=1 for exactly this one cycle; go to IDLE.
- `wb_dat_o` holds its value until the next CPU read completes.
- Wait counter, 8 bits:
  - Cleared in IDLE.
  - Increments each PEND cycle; saturates at 255.
  - `starve_o` = (count ≥ MAX_WAIT) while in PEND.
- When the bus is idle, the csr outputs are all 0: `stb`, `we`, `adr`, `sel`, `dat`.

## Timing
- Reset values: state IDLE, `wb_ack_o`=0, `wb_dat_o`=0, hold register 0, wait counter 0, `starve_o`=0, `csr_stb_o`=0 (given `disp_stb_i`=0).
- Display latency is 1 cycle, independent of CPU activity.
- CPU latency, request first seen at cycle 0, display idle:
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycle 1, data captured at end of cycle 2, ack in cycle 3.
- Each cycle `disp_stb_i` is high during PEND adds one cycle of latency.
- CPU does not stall the display: a display strobe in the same cycle as CPU capture wins; the CPU issues in the next idle cycle.
- If the master drops `wb_cyc_i` while in PEND/RD_DATA/ACK, the access still completes and the ack is still generated. No abort.
- Synchronous reset in any state aborts immediately:
  - No csr strobe for the held request after reset.
  - No ack issued.

## Structure
- Shared package `vga_pkg`: FSM state encoding (IDLE/PEND/RD_DATA/ACK) and the CSR address width constant (17).
- One sub-module is natural: `vga_mem_hold`, the CPU request hold register plus saturating wait counter. The arbiter top keeps the FSM and the csr output mux.

## Test plan
- Reset, then idle: all outputs 0; `disp_stb_i`=1 with adr 0x00100 → `csr_stb_o`=1, `csr_adr_o`=0x00100. Next cycle `disp_dat_o` equals the memory model word.
- CPU write 0xBEEF to 0x01234, sel 2'b01, display idle → csr write strobe in cycle 1; `wb_ack_o` pulses in cycle 2 for exactly 1 cycle; memory low byte = 0xEF.
- CPU read of 0x01234 (contents 0xA5A5), display idle → ack in cycle 3 with `wb_dat_o`=0xA5A5.
- CPU read while display strobes for 10 consecutive cycles → all 10 display reads return correct data at 1-cycle latency. CPU strobe in the first idle cycle; ack 2 cycles later.
- MAX_WAIT=4, display strobing continuously, CPU request pending → `starve_o` rises in the 5th PEND cycle (count=4); no CPU strobe issued.
- Reset asserted in RD_DATA → next cycle: state IDLE, `wb_ack_o`=0, `wb_dat_o`=0; no ack ever follows for that request.
